// File: rtl/exec_pkg.sv
// Shared widths, opcodes and FSM state type for the execute stage.
package exec_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_SLL = 3'd5;
    localparam logic [OP_W-1:0] OP_SRL = 3'd6;
    localparam logic [OP_W-1:0] OP_MUL = 3'd7;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_e;

endpackage

// File: rtl/execute_unit_seq_multiplier.sv
// Shift-and-add multiplier: one partial product per cycle, DATA_W cycles, no early exit.
module seq_multiplier #(
    parameter int unsigned DATA_W = exec_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic              running;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] multiplicand;
    logic [DATA_W-1:0] multiplier;
    logic [DATA_W-1:0] addend;

    // product includes the current iteration so the last step can be written back on the same edge
    assign addend  = multiplier[0] ? multiplicand : '0;
    assign product = acc + addend;
    assign done    = running && (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running      <= 1'b0;
            count        <= '0;
            acc          <= '0;
            multiplicand <= '0;
            multiplier   <= '0;
        end else if (start) begin
            running      <= 1'b1;
            count        <= CNT_W'(DATA_W - 1);
            acc          <= '0;
            multiplicand <= a;
            multiplier   <= b;
        end else if (running) begin
            acc          <= product;
            multiplicand <= multiplicand << 1;
            multiplier   <= multiplier >> 1;
            if (count == '0) begin
                running <= 1'b0;
            end else begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU plus iterative MUL, producing register-file write-back strobes.
module execute_unit #(
    parameter int unsigned DATA_W = exec_pkg::DATA_W,
    parameter int unsigned ADDR_W = exec_pkg::ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [exec_pkg::OP_W-1:0] op,
    input  logic [ADDR_W-1:0]         rd_addr,
    input  logic [DATA_W-1:0]         src1,
    input  logic [DATA_W-1:0]         src2,
    output logic                      wb_valid,
    output logic [ADDR_W-1:0]         wb_addr,
    output logic [DATA_W-1:0]         wb_data,
    output logic                      wb_zero,
    output logic                      busy
);

    import exec_pkg::*;

    localparam int unsigned SHAMT_W = $clog2(DATA_W);

    state_e             state;
    logic [ADDR_W-1:0]  mulRd;
    logic [DATA_W-1:0]  aluResult;
    logic [DATA_W-1:0]  mulProduct;
    logic [SHAMT_W-1:0] shamt;
    logic               mulDone;
    logic               mulStart;

    assign shamt    = src2[SHAMT_W-1:0];
    assign in_ready = (state == S_IDLE);
    assign mulStart = (state == S_IDLE) && in_valid && (op == OP_MUL);

    // Combinational ALU; MUL is handled by the sequential multiplier
    always_comb begin
        aluResult = '0;
        case (op)
            OP_ADD: aluResult = src1 + src2;
            OP_SUB: aluResult = src1 - src2;
            OP_AND: aluResult = src1 & src2;
            OP_OR:  aluResult = src1 | src2;
            OP_XOR: aluResult = src1 ^ src2;
            OP_SLL: aluResult = src1 << shamt;
            OP_SRL: aluResult = src1 >> shamt;
            default: aluResult = '0;
        endcase
    end

    seq_multiplier #(
        .DATA_W(DATA_W)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mulStart),
        .a      (src1),
        .b      (src2),
        .done   (mulDone),
        .product(mulProduct)
    );

    // Issue FSM and write-back registers; wb_addr/data/zero hold between strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            mulRd    <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            wb_zero  <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (op == OP_MUL) begin
                            state <= S_MUL;
                            busy  <= 1'b1;
                            mulRd <= rd_addr;
                        end else begin
                            wb_valid <= 1'b1;
                            wb_addr  <= rd_addr;
                            wb_data  <= aluResult;
                            wb_zero  <= (aluResult == '0);
                        end
                    end
                end
                S_MUL: begin
                    if (mulDone) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_addr  <= mulRd;
                        wb_data  <= mulProduct;
                        wb_zero  <= (mulProduct == '0);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/execute_unit.md
# execute_unit

Execute stage that sits directly downstream of the 8×32 register file. It consumes the two read-port operands plus an opcode and destination address, computes an ALU result, and emits a one-cycle write-back strobe (data and address) that drives the register file write port. Single-cycle ops issue back-to-back. MUL is iterative with fixed latency and holds off new issues while busy.

## Interface
- DATA_W, 32: operand, result and register width
- ADDR_W, 3: register address width (8 registers)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  issue request; op, rd_addr, src1 and src2 are valid
- in_ready  out  1  issue accepted when in_valid && in_ready at a clk edge
- op  in  3  opcode (see Operation)
- rd_addr  in  ADDR_W  destination register
- src1  in  DATA_W  operand A, from register file read port 1
- src2  in  DATA_W  operand B, from register file read port 2
- wb_valid  out  1  register file write enable, one-cycle pulse per result
- wb_addr  out  ADDR_W  register file write address
- wb_data  out  DATA_W  register file write data
- wb_zero  out  1  wb_data == 0, qualified by wb_valid
- busy  out  1  high while a MUL is in progress

## Operation
- Opcodes:
  - 000 ADD
  - 001 SUB (src1 − src2)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLL by src2[4:0]
  - 110 SRL (logical) by src2[4:0]
  - 111 MUL (low DATA_W bits)
- All arithmetic is modulo 2^DATA_W. Carry and overflow are discarded. Shifts ignore src2[DATA_W-1:5].
- FSM states:
  - IDLE: accepts any op.
  - MUL: iterating. Counter runs DATA_W−1 down to 0.
- Transitions:
  - IDLE → MUL on an accepted op 111.
  - MUL → IDLE after the DATA_W-th iteration.
  - An accepted ALU op stays in IDLE.
- MUL algorithm: latch src1 as multiplicand, src2 as multiplier, and rd_addr. Each cycle, if multiplier[0] is set, add multiplicand to the accumulator. Then shift the multiplicand left 1 and the multiplier right 1. No early termination.
- in_ready = (state == IDLE). While in MUL, in_valid is ignored; the upstream must hold its request.
- Register 0 is an ordinary register; there is no special-casing of wb_addr == 0.
- Reset asserted at any time:
  - State goes to IDLE.
  - The counter and accumulator clear.
  - wb_valid, wb_addr, wb_data, wb_zero and busy go to 0.
  - An in-flight MUL is discarded and never written back.
- Inputs are ignored while rst is high.

## Timing
- ALU op accepted at edge N: wb_valid = 1 for exactly the cycle after edge N. wb_addr, wb_data and wb_zero are registered at edge N.
- Back-to-back ALU ops give one wb_valid per cycle with no bubble.
- MUL accepted at edge N: busy = 1 from edge N to edge N+DATA_W. wb_valid is set at edge N+DATA_W for one cycle, and busy falls at that same edge. The next issue is accepted at edge N+DATA_W.
- wb_valid is never asserted for two different results in the same cycle.
- wb_addr, wb_data and wb_zero hold their last values when wb_valid = 0.

## Structure
- Package exec_pkg holds:
  - DATA_W and ADDR_W defaults
  - opcode constants OP_ADD through OP_MUL
  - state enum {S_IDLE, S_MUL}
- Sub-module seq_multiplier:
  - Ports: clk, rst, start, a, b, done, product.
  - Owns the counter, accumulator and shift registers. done pulses for one cycle.
- The top level holds the combinational ALU, the FSM, the rd_addr latch and the write-back registers.

## Test plan
- ADD with src1 = 0xACEDCAFE, src2 = 0xDEADBEEF, rd = 3 → next cycle wb_valid = 1, wb_addr = 3, wb_data = 0x8B9B89ED, wb_zero = 0.
- SUB 5 − 7 → 0xFFFFFFFE. Then XOR 0xDEADBEEF ^ 0xDEADBEEF → 0x00000000 with wb_zero = 1. Both issued back-to-back, giving wb_valid on two consecutive cycles.
- SLL with src1 = 1, src2 = 31 → 0x80000000. SLL with src2 = 32 → 1 (shift amount 0). SRL of 0x80000000 by 31 → 1.
- MUL:
  - 0x00010003 × 5 into rd = 7 → busy for 32 cycles, in_ready = 0, then wb_data = 0x0005000F and wb_addr = 7 exactly 32 cycles after acceptance.
  - 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001.
- During a MUL, hold in_valid with an ADD → no acceptance until busy drops. The ADD is then accepted and written back the following cycle, and the MUL result is not corrupted.
- Assert rst at cycle 10 of a MUL → all outputs 0 immediately with in_ready = 1, and no wb_valid ever appears for the aborted MUL.
